// File: rtl/ws2812_stream_decoder_pkg.sv
// Shared state type and timing constants for the WS2812 receive path.
// Widths are in 40 MHz clk cycles.
package ws2812_pkg;

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    localparam int WORD_BITS       = 24;
    localparam int CNT_BITS        = 12;

    localparam int HIGH_THRESH_DEF = 24;
    localparam int MIN_HIGH_DEF    = 4;
    localparam int MAX_HIGH_DEF    = 60;
    localparam int RESET_LOW_DEF   = 1000;

    // Nominal transmitter widths, used by loopback benches.
    localparam int T0H     = 17;
    localparam int T1H     = 33;
    localparam int T0L     = 35;
    localparam int T1L     = 19;
    localparam int T_RESET = 2000;

    function automatic logic [CNT_BITS-1:0] satInc(input logic [CNT_BITS-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/ws2812_stream_decoder_if.sv
// Serial line in, decoded pixel/frame stream out.
// master = decoder side, slave = consumer / line driver side.
interface ws2812_stream_decoder_if;

    logic        din;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [7:0]  pixel_index;
    logic        frame_done;
    logic [7:0]  frame_pixels;
    logic        err;

    modport master (
        input  din,
        output pixel_data, pixel_valid, pixel_index, frame_done, frame_pixels, err
    );

    modport slave (
        output din,
        input  pixel_data, pixel_valid, pixel_index, frame_done, frame_pixels, err
    );

endinterface

// File: rtl/ws2812_stream_decoder_sync_edge.sv
// Two-flop synchronizer for the async serial line with registered edge pulses.
// Edge pulses are timed to coincide with the synchronized level change, adding no latency.
module ws2812_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    output logic s_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic s_q;
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            s_q    <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= din_i;
            s_q    <= meta_q;
            rise_q <= meta_q & ~s_q;
            fall_q <= ~meta_q & s_q;
        end
    end

    assign s_o    = s_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/ws2812_stream_decoder.sv
// WS2812 NRZ receiver: measures high pulse widths, assembles 24-bit words LSB-first,
// counts pixels per frame and detects the inter-frame reset gap.
module ws2812_stream_decoder
    import ws2812_pkg::*;
#(
    parameter int HIGH_THRESH = HIGH_THRESH_DEF,
    parameter int MIN_HIGH    = MIN_HIGH_DEF,
    parameter int MAX_HIGH    = MAX_HIGH_DEF,
    parameter int RESET_LOW   = RESET_LOW_DEF
) (
    input logic                     clk,
    input logic                     reset,
    ws2812_stream_decoder_if.master bus
);

    localparam logic [CNT_BITS-1:0] HighThreshC = 12'(HIGH_THRESH);
    localparam logic [CNT_BITS-1:0] MinHighC    = 12'(MIN_HIGH);
    localparam logic [CNT_BITS-1:0] MaxHighC    = 12'(MAX_HIGH);
    localparam logic [CNT_BITS-1:0] ResetLowM1C = 12'(RESET_LOW - 1);
    localparam logic [4:0]          LastBitC    = 5'(WORD_BITS - 1);

    logic s;
    logic rise;
    logic fall;

    ws2812_sync_edge u_sync (
        .clk    (clk),
        .reset  (reset),
        .din_i  (bus.din),
        .s_o    (s),
        .rise_o (rise),
        .fall_o (fall)
    );

    state_t                state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [4:0]            bitCnt_q, bitCnt_d;
    logic [23:0]           shift_q, shift_d;
    logic [7:0]            frameCnt_q, frameCnt_d;
    logic [23:0]           pixelData_q, pixelData_d;
    logic                  pixelValid_q, pixelValid_d;
    logic [7:0]            pixelIndex_q, pixelIndex_d;
    logic                  frameDone_q, frameDone_d;
    logic [7:0]            framePixels_q, framePixels_d;
    logic                  err_q, err_d;

    logic                  lowDone;
    logic                  bitVal;
    logic [23:0]           word;

    // cnt_q equals the finished high width on the fall cycle, and cycles held so far minus one otherwise.
    assign cnt_d   = (rise || fall) ? 12'd1 : satInc(cnt_q);
    assign lowDone = !s && !fall && (cnt_q >= ResetLowM1C);
    assign bitVal  = (cnt_q >= HighThreshC);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= SYNC;
            cnt_q         <= '0;
            bitCnt_q      <= '0;
            shift_q       <= '0;
            frameCnt_q    <= '0;
            pixelData_q   <= '0;
            pixelValid_q  <= 1'b0;
            pixelIndex_q  <= '0;
            frameDone_q   <= 1'b0;
            framePixels_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bitCnt_q      <= bitCnt_d;
            shift_q       <= shift_d;
            frameCnt_q    <= frameCnt_d;
            pixelData_q   <= pixelData_d;
            pixelValid_q  <= pixelValid_d;
            pixelIndex_q  <= pixelIndex_d;
            frameDone_q   <= frameDone_d;
            framePixels_q <= framePixels_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bitCnt_d      = bitCnt_q;
        shift_d       = shift_q;
        frameCnt_d    = frameCnt_q;
        pixelData_d   = pixelData_q;
        pixelIndex_d  = pixelIndex_q;
        framePixels_d = framePixels_q;
        pixelValid_d  = 1'b0;
        frameDone_d   = 1'b0;
        err_d         = 1'b0;
        word          = shift_q;
        word[bitCnt_q] = bitVal;

        case (state_q)
            SYNC: begin
                bitCnt_d   = '0;
                shift_d    = '0;
                frameCnt_d = '0;
                if (lowDone) state_d = IDLE;
            end
            IDLE: begin
                if (rise) state_d = HIGH;
            end
            HIGH: begin
                if (fall) begin
                    if (cnt_q < MinHighC) begin
                        err_d   = 1'b1;
                        state_d = SYNC;
                    end else begin
                        state_d = LOW;
                        if (bitCnt_q == LastBitC) begin
                            bitCnt_d = '0;
                            shift_d  = '0;
                            // A 256th pixel has no room in the count; it is flagged instead of emitted.
                            if (frameCnt_q == 8'hFF) begin
                                err_d        = 1'b1;
                                pixelIndex_d = 8'hFF;
                            end else begin
                                pixelData_d  = word;
                                pixelValid_d = 1'b1;
                                pixelIndex_d = frameCnt_q;
                                frameCnt_d   = frameCnt_q + 8'd1;
                            end
                        end else begin
                            shift_d  = word;
                            bitCnt_d = bitCnt_q + 5'd1;
                        end
                    end
                end else if (cnt_q >= MaxHighC) begin
                    err_d   = 1'b1;
                    state_d = SYNC;
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                end else if (lowDone) begin
                    if (bitCnt_q == '0) begin
                        if (frameCnt_q != '0) begin
                            frameDone_d   = 1'b1;
                            framePixels_d = frameCnt_q;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                    bitCnt_d   = '0;
                    shift_d    = '0;
                    frameCnt_d = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    assign bus.pixel_data   = pixelData_q;
    assign bus.pixel_valid  = pixelValid_q;
    assign bus.pixel_index  = pixelIndex_q;
    assign bus.frame_done   = frameDone_q;
    assign bus.frame_pixels = framePixels_q;
    assign bus.err          = err_q;

endmodule

// File: doc/ws2812_stream_decoder.md
Name: ws2812_stream_decoder

Overview:
- Receive-side counterpart of the LED datastream generator. Samples a single-wire WS2812B-style NRZ line and measures high-pulse widths in clk cycles (40 MHz).
- Recovers each 24-bit colour word in transmit order, with the first received bit placed at bit 0. Counts pixels per frame and detects the inter-frame reset gap.
- Used to self-check the matrix driver in loopback, and as the input stage for chaining a downstream panel.

Parameters:
- HIGH_THRESH, 24: high width (cycles) >= HIGH_THRESH decodes as 1, otherwise 0.
- MIN_HIGH, 4: high width < MIN_HIGH is a glitch and is flagged as an error.
- MAX_HIGH, 60: high width > MAX_HIGH is flagged as an error. Detected while still high.
- RESET_LOW, 1000: consecutive low cycles that end a frame or arm the receiver. Must be <= 4095.

Ports:
- clk, in, 1: system clock, 40 MHz.
- reset, in, 1: synchronous, active-high. Clock is clk.
- din, in, 1: asynchronous serial line.
- pixel_data, out, 24: last decoded word. Holds its value between pulses.
- pixel_valid, out, 1: one-cycle pulse when pixel_data updates.
- pixel_index, out, 8: index of the pixel in pixel_data within the current frame.
- frame_done, out, 1: one-cycle pulse when a reset gap ends a frame containing at least 1 pixel.
- frame_pixels, out, 8: pixel count of the last completed frame. Valid from frame_done onward.
- err, out, 1: one-cycle pulse on any protocol violation.

Behaviour:
- Input path: din passes through a 2-flop synchronizer to give s. All widths are measured on s. Edge detect compares s with its previous value.
- Reset values: all outputs 0; state SYNC; all counters 0; shift register 0.
- Width counter: 12 bits, saturating at 4095. Clears on every edge of s, then counts the cycles s holds its level.
- State SYNC: wait for RESET_LOW consecutive lows of s, then go to IDLE. Any high clears the count. Bits are never decoded in SYNC.
- State IDLE: armed with bit count 0. Rising edge of s goes to HIGH.
- State HIGH, count exceeds MAX_HIGH: pulse err, discard partial word, go to SYNC.
- State HIGH, falling edge of s: classify width w.
  - w < MIN_HIGH: pulse err, go to SYNC.
  - Otherwise: bit = (w >= HIGH_THRESH). Store it at position bitcount; bitcount++. Go to LOW.
- 24th bit (bitcount reaches 24): on the same clk edge as the HIGH->LOW transition:
  - load pixel_data and pulse pixel_valid;
  - pixel_index = current frame pixel count;
  - increment the frame pixel count, saturating at 255;
  - clear bitcount.
  - Total latency from din falling to pixel_valid is 3 cycles: 2 synchronizer + 1 register.
- State LOW, rising edge of s: go to HIGH. Low width is not checked against a minimum.
- State LOW, low count reaches RESET_LOW, bitcount = 0: if the frame pixel count > 0, pulse frame_done and load frame_pixels. Clear the frame count; go to IDLE.
- State LOW, low count reaches RESET_LOW, bitcount != 0: partial pixel. Pulse err; discard the word and the frame count; no frame_done; go to IDLE.
- Pixel count saturation: a 256th pixel in one frame pulses err. pixel_index holds at 255; decoding continues.
- Simultaneous events: at most one of pixel_valid, frame_done and err pulses per cycle, since they arise from exclusive transitions. err has priority over pixel_valid on the same edge.
- Reset mid-frame: returns to SYNC immediately. pixel_data clears; no pulses occur in the reset cycle.

Decomposition:
- Package ws2812_pkg holds:
  - the state typedef {SYNC, IDLE, HIGH, LOW};
  - default timing constants, plus the transmitter's nominal widths (T0H 17, T1H 33, T0L 35, T1L 19, RESET 2000) for benches;
  - WORD_BITS = 24.
- One sub-module, ws2812_sync_edge: 2-flop synchronizer with registered rise/fall pulse outputs.
- FSM, counters and word assembly stay in the top module.

Test Plan:
- Reset low for 1000 cycles, then send 24'h00B000 with nominal widths, then 2000 low -> pixel_valid 3 cycles after the last fall; pixel_data = 24'h00B000, pixel_index 0; frame_done with frame_pixels 1.
- Send 9 words (24'h909090, 24'hB00000, 24'h0000B0, 24'h00F060 repeated, 24'h000000), then the gap -> 9 pixel_valid pulses, indices 0..8, data in order; frame_done with frame_pixels 9.
- Boundary widths: highs of 23 and 24 cycles decode as 0 and 1; a 3-cycle high gives err and no pixel_valid; a 61-cycle high gives err at cycle 61 of the high.
- Send 10 bits, then 1000 low -> err pulse; no frame_done. A next full word decodes at index 0.
- Bits sent before any reset gap after reset deassert -> ignored in SYNC. After 1000 low cycles, the first word is received correctly.
- Assert reset during bit 12 of a word -> outputs 0, state SYNC. A following gap plus full word decodes correctly.
